// File: rtl/qmac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : qmac_accum
//  Purpose  : Saturating accumulator for a stream of LEN signed Q-format
//             products; returns one dot-product term over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module qmac_accum #(
    parameter int N   = 32,
    parameter int Q   = 18,
    parameter int LEN = 3,
    parameter int CW  = $clog2(LEN + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_ovr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovr,
    output logic         busy
);

    // Q only describes the number format; the adds are plain integer adds.
    if ((Q < 0) || (Q >= N) || (LEN < 1)) begin : g_param_check
        $error("qmac_accum: invalid Q/LEN parameterisation");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0]  C_POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  C_NEG_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] C_LAST    = CW'(LEN - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          sticky_q, sticky_d;

    logic [N:0]    w_sum;
    logic          w_sat;

    always_comb begin
        w_sum = {acc_q[N-1], acc_q} + {in_data[N-1], in_data};
        // Sign of the N+1-bit sum disagreeing with bit N-1 means it left the N-bit range.
        w_sat = w_sum[N] ^ w_sum[N-1];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ACC;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    if (w_sat) begin
                        acc_d = w_sum[N] ? C_NEG_MIN : C_POS_MAX;
                    end else begin
                        acc_d = w_sum[N-1:0];
                    end
                    sticky_d = sticky_q | in_ovr | w_sat;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        state_d  = S_ACC;
                        acc_d    = '0;
                        cnt_d    = '0;
                        sticky_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    // Outputs are decoded from registered state only; no input reaches an output combinationally.
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_DONE);
        out_data  = (state_q == S_DONE) ? acc_q : '0;
        out_ovr   = (state_q == S_DONE) ? sticky_q : 1'b0;
        busy      = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire
